// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the unified instruction/data memory between the multicycle core
// and the debug/program-loader port. Every access runs IDLE -> ISSUE ->
// (WAIT) -> RESP, and the winning requester gets a one-cycle ack at the end.
// All outputs are registered. last_owner and owner are the same register:
// owner always names the port that was granted most recently.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int READ_LAT = 2     // legal range 1..15 (4-bit wait counter)
) (
    input  logic          clk,
    input  logic          reset,
    // core side
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    // debug / loader side
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    input  logic          dbg_lock,
    // memory macro side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Counter reload value: the counter reaches zero in the cycle where
    // mem_rdata becomes valid.
    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t        r_state;
    logic          r_we;          // latched write flag of the access in flight
    logic [3:0]    r_cnt;         // read latency down-counter
    logic          r_owner;       // current / last owner, also last_owner
    logic          r_busy;
    logic          r_mem_en;
    logic          r_mem_we;
    logic          r_cpu_ack;
    logic          r_dbg_ack;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dbg_rdata;

    logic          w_cpu_elig;
    logic          w_dbg_elig;
    logic          w_any_elig;
    logic          w_pick_dbg;
    logic          w_grant;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_capture;

    // The lock only holds off new core grants; debug is always eligible.
    assign w_cpu_elig = cpu_req & ~dbg_lock;
    assign w_dbg_elig = dbg_req;
    assign w_any_elig = w_cpu_elig | w_dbg_elig;

    // Debug wins when it is alone, or on a tie when the core went last.
    // Reset leaves r_owner at dbg so the core wins the first tie.
    assign w_pick_dbg = w_dbg_elig & (~w_cpu_elig | (r_owner == OWN_CPU));

    assign w_grant     = (r_state == ST_IDLE) & w_any_elig;
    assign w_sel_we    = w_pick_dbg ? dbg_we    : cpu_we;
    assign w_sel_addr  = w_pick_dbg ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = w_pick_dbg ? dbg_wdata : cpu_wdata;

    // Read data is sampled in the last WAIT cycle, where it is valid.
    assign w_capture = (r_state == ST_WAIT) & (r_cnt == 4'd0);

    // Access sequencer: state, handshake pulses, strobes and ownership.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_cnt     <= 4'd0;
            r_owner   <= OWN_DBG;
            r_busy    <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_elig) begin
                        r_owner  <= w_pick_dbg;
                        r_we     <= w_sel_we;
                        r_mem_en <= 1'b1;
                        r_mem_we <= w_sel_we;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_we) begin
                        // Writes complete as soon as the strobe has gone out.
                        r_cpu_ack <= (r_owner == OWN_CPU);
                        r_dbg_ack <= (r_owner == OWN_DBG);
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_cpu_ack <= (r_owner == OWN_CPU);
                        r_dbg_ack <= (r_owner == OWN_DBG);
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address/data latches toward memory and per-port read-data holding registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
            // Each port's register changes only on that port's own reads.
            if (w_capture && (r_owner == OWN_CPU)) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (w_capture && (r_owner == OWN_DBG)) begin
                r_dbg_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign dbg_rdata = r_dbg_rdata;
    assign dbg_ack   = r_dbg_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule
